// File: rtl/i2c_slave_ms72xx.sv
// i2c_slave_ms72xx: I2C target with a 7-bit device address, an 8/16-bit register
// pointer (MSB byte first), 8-bit data and auto-increment, exposed as a register bus.
// SCL/SDA are oversampled on clk. Optional glitch filter: define I2C_GLITCH_FILTER_EN.
module i2c_slave_ms72xx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h59,
  parameter bit         BIT_CTRL   = 1'b1,
  parameter int         FILT_LEN   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_RADDR_H, S_RADDR_L,
    S_WR_DATA, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  // Input stage: bit 0 carries SCL, bit 1 carries SDA.
  logic       w_sda_pin;
  logic [1:0] r_sync1, r_sync2, r_prev, w_filt;
  logic       w_scl, w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;

  assign w_sda_pin = sda;

  // Two-flop synchroniser; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {w_sda_pin, scl};
      r_sync2 <= r_sync1;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_filt
    logic [FILT_LEN-2:0] r_hist;
    logic                r_level;
    logic [FILT_LEN-1:0] w_window;
    assign w_window = {r_hist, r_sync2[gi]};
    // The filtered level moves only when the whole sample window agrees.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hist  <= '1;
        r_level <= 1'b1;
      end else begin
        r_hist <= w_window[FILT_LEN-2:0];
        if (&w_window)
          r_level <= 1'b1;
        else if (~|w_window)
          r_level <= 1'b0;
      end
    end
    assign w_filt[gi] = r_level;
  end
`else
  assign w_filt = r_sync2;
`endif

  assign w_scl = w_filt[0];
  assign w_sda = w_filt[1];

  // Previous sample for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 2'b11;
    else        r_prev <= w_filt;
  end

  assign w_start    = r_prev[0] & w_scl & r_prev[1] & ~w_sda;
  assign w_stop     = r_prev[0] & w_scl & ~r_prev[1] & w_sda;
  assign w_scl_rise = ~r_prev[0] & w_scl;
  assign w_scl_fall = r_prev[0] & ~w_scl;

  // Protocol state and datapath registers.
  state_t      r_state, w_state_next;
  logic [3:0]  r_bit_cnt, w_cnt_next;
  logic [7:0]  r_shift, w_shift_next, w_byte;
  logic [15:0] r_addr, w_addr_next;
  logic [7:0]  r_wdata, w_wdata_next;
  logic        r_sda_oe, w_oe_next, r_wr_en, w_wr_next, r_rd_req, w_rd_req_next;
  logic        r_rd_en, r_rd_load, r_busy, w_busy_next, r_rw, w_rw_next;

  // Byte as it stands once the current rising-edge bit is shifted in.
  assign w_byte = {r_shift[6:0], w_sda};

  // Pointer increment honouring the configured address width.
  function automatic logic [15:0] f_inc(input logic [15:0] a);
    if (BIT_CTRL) return a + 16'd1;
    else          return {8'h00, a[7:0] + 8'd1};
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_sda_oe  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_req  <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_cnt_next;
      r_shift   <= w_shift_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_sda_oe  <= w_oe_next;
      r_wr_en   <= w_wr_next;
      r_rd_req  <= w_rd_req_next;
      r_busy    <= w_busy_next;
      r_rw      <= w_rw_next;
    end
  end

  // Read request pipeline: strobe, then capture reg_rdata one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_load <= 1'b0;
    end else begin
      r_rd_en   <= r_rd_req;
      r_rd_load <= r_rd_en;
    end
  end

  // Next-state logic; r_bit_cnt counts SCL rising edges within a byte (9 = ACK clock seen).
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_bit_cnt;
    w_shift_next  = r_shift;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_oe_next     = r_sda_oe;
    w_wr_next     = 1'b0;
    w_rd_req_next = 1'b0;
    w_busy_next   = r_busy;
    w_rw_next     = r_rw;
    if (r_wr_en)   w_addr_next  = f_inc(r_addr);
    if (r_rd_load) w_shift_next = reg_rdata;
    if (w_stop) begin
      w_state_next = S_IDLE;
      w_cnt_next   = 4'd0;
      w_oe_next    = 1'b0;
      w_busy_next  = 1'b0;
    end else if (w_start) begin
      w_state_next = S_DEV_ADDR;
      w_cnt_next   = 4'd0;
      w_oe_next    = 1'b0;
    end else begin
      case (r_state)
        S_DEV_ADDR: begin
          if (w_scl_rise) begin
            w_shift_next = w_byte;
            w_cnt_next   = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_state_next = S_DEV_ACK;
                w_rw_next    = w_byte[0];
                w_busy_next  = 1'b1;
              end else begin
                w_state_next = S_IGNORE;
                w_busy_next  = 1'b0;
              end
            end
          end
        end
        S_DEV_ACK: begin
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_oe_next = 1'b1;
          end else if (w_scl_rise && r_bit_cnt == 4'd8) begin
            w_cnt_next    = 4'd9;
            w_rd_req_next = r_rw;
          end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
            w_cnt_next = 4'd0;
            if (r_rw) begin
              w_state_next = S_RD_DATA;
              w_oe_next    = ~r_shift[7];
            end else begin
              w_state_next = BIT_CTRL ? S_RADDR_H : S_RADDR_L;
              w_oe_next    = 1'b0;
            end
          end
        end
        S_RADDR_H, S_RADDR_L, S_WR_DATA: begin
          if (w_scl_rise && r_bit_cnt < 4'd8) begin
            w_shift_next = w_byte;
            w_cnt_next   = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              if (r_state == S_RADDR_H)      w_addr_next[15:8] = w_byte;
              else if (r_state == S_RADDR_L) w_addr_next[7:0]  = w_byte;
              else begin
                w_wdata_next = w_byte;
                w_wr_next    = 1'b1;
              end
            end
          end else if (w_scl_rise && r_bit_cnt == 4'd8) begin
            w_cnt_next = 4'd9;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_oe_next = 1'b1;
          end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
            w_oe_next  = 1'b0;
            w_cnt_next = 4'd0;
            if (r_state == S_RADDR_H)      w_state_next = S_RADDR_L;
            else if (r_state == S_RADDR_L) w_state_next = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise && r_bit_cnt < 4'd8) begin
            w_cnt_next = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_oe_next    = 1'b0;
            w_state_next = S_RD_ACK;
          end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
            w_shift_next = {r_shift[6:0], 1'b0};
            w_oe_next    = ~r_shift[6];
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise && r_bit_cnt == 4'd8) begin
            if (!w_sda) begin
              w_cnt_next    = 4'd9;
              w_addr_next   = f_inc(r_addr);
              w_rd_req_next = 1'b1;
            end else begin
              w_state_next = S_IGNORE;
              w_busy_next  = 1'b0;
            end
          end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
            w_state_next = S_RD_DATA;
            w_cnt_next   = 4'd0;
            w_oe_next    = ~r_shift[7];
          end
        end
        default: ;
      endcase
    end
  end

  // Open-drain drive; a STOP releases the line in the cycle it is seen.
  assign sda       = (r_sda_oe && !w_stop) ? 1'b0 : 1'bz;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wr_en = r_wr_en;
  assign reg_rd_en = r_rd_en;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_ms72xx.sv
// tb_i2c_slave_ms72xx: directed and randomized I2C master transactions against a
// transaction-level model of the register pointer and register contents.
module tb_i2c_slave_ms72xx;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         sda;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr_en, reg_rd_en, busy;
  logic [7:0]  reg_rdata = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_ms72xx dut (
    .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register file behind the bus: registered read, unwritten cells read as addr[7:0].
  logic [7:0] dev_mem [0:65535];
  bit         dev_wr  [0:65535];
  always @(posedge clk) begin
    if (reg_wr_en) begin
      dev_mem[reg_addr] <= reg_wdata;
      dev_wr[reg_addr]  <= 1'b1;
    end
    if (reg_rd_en) reg_rdata <= dev_wr[reg_addr] ? dev_mem[reg_addr] : reg_addr[7:0];
  end

  // Strobe log sampled away from the active edge.
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int rd_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
    end
    if (reg_rd_en) rd_cnt++;
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  // Reference model: pointer and written contents.
  logic [15:0] m_ptr = 16'h0000;
  logic [7:0]  m_mem [int];
  function automatic logic [7:0] m_get(input logic [15:0] a);
    if (m_mem.exists(int'(a))) return m_mem[int'(a)];
    return a[7:0];
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_sda_low = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda_low = 1'b1; wq(); m_scl = 1'b0; wq();
  endtask
  task automatic i2c_stop();
    m_sda_low = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda_low = 1'b0; wq(); wq();
  endtask
  task automatic wbit(input logic b);
    m_sda_low = ~b; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
  endtask
  task automatic rbit(output logic b);
    m_sda_low = 1'b0; wq(); m_scl = 1'b1; wq(); b = sda; wq(); m_scl = 1'b0; wq();
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(nack);
  endtask

  // START, device write address, pointer bytes.
  task automatic tx_set_ptr(input logic [15:0] a);
    logic ack;
    i2c_start();
    wbyte(8'hB2, ack); chk("dev_ack", ack, 1'b0);
    chk("busy_addressed", busy, 1'b1);
    wbyte(a[15:8], ack); chk("addr_h_ack", ack, 1'b0);
    wbyte(a[7:0], ack);  chk("addr_l_ack", ack, 1'b0);
    m_ptr = a;
  endtask

  task automatic tx_write(input logic [15:0] a, input int n, input logic [7:0] d [8]);
    logic ack;
    int base;
    base = wr_addr_q.size();
    tx_set_ptr(a);
    for (int i = 0; i < n; i++) begin
      wbyte(d[i], ack); chk("data_ack", ack, 1'b0);
    end
    i2c_stop();
    chk("wr_count", wr_addr_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_addr_q.size()) begin
        chk("wr_addr", wr_addr_q[base + i], m_ptr);
        chk("wr_data", wr_data_q[base + i], d[i]);
      end
      m_mem[int'(m_ptr)] = d[i];
      m_ptr = m_ptr + 16'd1;
    end
    $display("write @%04h n=%0d -> ptr %04h", a, n, reg_addr);
    chk("ptr_after_write", reg_addr, m_ptr);
    chk("busy_after_stop", busy, 1'b0);
  endtask

  task automatic tx_read(input logic [15:0] a, input int n);
    logic ack;
    logic [7:0] d;
    int base;
    base = rd_cnt;
    tx_set_ptr(a);
    i2c_start();
    wbyte(8'hB3, ack); chk("rd_dev_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      rbyte(i == n - 1, d);
      chk("rd_data", d, m_get(m_ptr));
      if (i < n - 1) m_ptr = m_ptr + 16'd1;
    end
    repeat (4) @(negedge clk);
    chk("sda_after_nack", sda, 1'b1);
    chk("busy_after_nack", busy, 1'b0);
    chk("rd_pulses", rd_cnt - base, n);
    i2c_stop();
    $display("read  @%04h n=%0d -> ptr %04h", a, n, reg_addr);
    chk("ptr_after_read", reg_addr, m_ptr);
  endtask

  initial begin
    logic [7:0] d [8];
    logic       ack, b;
    int         base, rbase;
    logic [15:0] a;

    repeat (3) @(negedge clk);
    chk("rst_sda", sda, 1'b1);
    chk("rst_addr", reg_addr, 16'h0000);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_wr_en", reg_wr_en, 1'b0);
    chk("rst_rd_en", reg_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single write of 0xA5 at 0x1234.
    d = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_write(16'h1234, 1, d);
    chk("ptr_1235", reg_addr, 16'h1235);

    // Burst across the 16-bit wrap.
    d = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_write(16'hFFFF, 3, d);

    // Pointer write, Sr, read two bytes.
    tx_read(16'h0010, 2);

    // Foreign address: no ACK, no strobes, not busy.
    base = wr_addr_q.size(); rbase = rd_cnt;
    i2c_start();
    wbyte(8'hA0, ack); chk("foreign_nack", ack, 1'b1);
    wbyte(8'h12, ack); chk("foreign_data_nack", ack, 1'b1);
    chk("foreign_busy", busy, 1'b0);
    i2c_stop();
    chk("foreign_wr", wr_addr_q.size() - base, 0);
    chk("foreign_rd", rd_cnt - rbase, 0);
    $display("foreign address 0xA0 -> ack=%0d busy=%0d", ack, busy);

    // STOP after four data bits.
    base = wr_addr_q.size();
    tx_set_ptr(16'h0020);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    chk("partial_wr", wr_addr_q.size() - base, 0);
    chk("partial_ptr", reg_addr, m_ptr);
    chk("partial_busy", busy, 1'b0);
    $display("partial byte + STOP -> ptr %04h", reg_addr);

    // Reset while the target drives read data (0x40 -> bits 0,1,0,0...).
    tx_set_ptr(16'h0040);
    i2c_start();
    wbyte(8'hB3, ack); chk("rst_rd_dev_ack", ack, 1'b0);
    rbit(b); chk("rst_rd_bit7", b, m_get(16'h0040) >> 7);
    rbit(b); chk("rst_rd_bit6", b, (m_get(16'h0040) >> 6) & 8'h01);
    rbit(b); chk("rst_rd_bit5", b, (m_get(16'h0040) >> 5) & 8'h01);
    chk("rst_rd_driving", sda, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sda", sda, 1'b1);
    chk("midrst_addr", reg_addr, 16'h0000);
    chk("midrst_wdata", reg_wdata, 8'h00);
    chk("midrst_wr_en", reg_wr_en, 1'b0);
    chk("midrst_rd_en", reg_rd_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 16'h0000;
    i2c_stop();
    $display("reset during read -> sda=%0b ptr %04h", sda, reg_addr);

    // Randomized bursts and read-back over a small window.
    for (int k = 0; k < 4; k++) begin
      a = 16'h0300 + 16'($urandom_range(0, 6));
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      tx_write(a, int'($urandom_range(1, 3)), d);
    end
    for (int k = 0; k < 3; k++) begin
      a = 16'h0300 + 16'($urandom_range(0, 6));
      tx_read(a, int'($urandom_range(1, 4)));
    end

    chk("wr_rd_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
